imem_arbiter: RTL and testbench

Two-port arbiter that shares the single combinational read port of the instruction memory between the CPU fetch stage (port 0) and a debug/trace reader (port 1). Each requester gets a valid/ready request channel and a registered response slot with backpressure. Port 0 has fixed priority, and a starvation counter bounds how long port 1 can wait. The arbiter sits between the fetch logic and the instruction memory in the top-level CPU.

---
 rtl/imem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_imem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Brief    : Shares the single combinational instruction-memory read port
//            between the CPU fetch stage (port 0, fixed priority) and a
//            debug/trace reader (port 1, starvation-bounded). Each port has a
//            valid/ready request channel and one registered response slot.
// Options  : IMEM_ARB_ALIGN_CHK_EN - when defined, misaligned or out-of-range
//            addresses return data 0 with the error flag set; otherwise the
//            error outputs are tied low and memory data passes through as-is.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_WORDS    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  output logic              req1_ready_o,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp0_data_o,
  output logic              rsp0_err_o,
  input  logic              rsp0_ready_i,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp1_data_o,
  output logic              rsp1_err_o,
  input  logic              rsp1_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_instr_i
);

  localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  // Elaboration-time sanity checks on the configuration.
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("imem_arbiter: STARVE_LIMIT must be at least 1");
  end
  if (MEM_WORDS < 1) begin : g_bad_mem_words
    $error("imem_arbiter: MEM_WORDS must be at least 1");
  end

  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  logic              elig0, elig1;
  logic              gnt0, gnt1;
  logic              starve_hit;
  logic [DATA_W-1:0] capture_data;

  // A port may be served when it has a request and its slot is free or
  // being drained this very cycle (that is what gives 1 response/cycle).
  assign elig0      = req0_valid_i && (!rsp0_valid_q || rsp0_ready_i);
  assign elig1      = req1_valid_i && (!rsp1_valid_q || rsp1_ready_i);
  assign starve_hit = (starve_cnt_q == STARVE_MAX);

  // Grant decision: port 0 by default, port 1 when port 0 cannot go or when
  // port 1 has waited long enough; nothing is granted while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_i) begin
      if (elig1 && (!elig0 || starve_hit)) begin
        gnt1 = 1'b1;
      end else if (elig0) begin
        gnt0 = 1'b1;
      end
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  // Memory address follows the winner; idle cycles drive zero.
  always_comb begin
    mem_addr_o = '0;
    if (gnt0) begin
      mem_addr_o = req0_addr_i;
    end else if (gnt1) begin
      mem_addr_o = req1_addr_i;
    end
  end

`ifdef IMEM_ARB_ALIGN_CHK_EN
  logic addr_bad;
  logic rsp0_err_q, rsp0_err_d;
  logic rsp1_err_q, rsp1_err_d;

  // Flag granted addresses that are not word aligned or fall past the end.
  always_comb begin
    addr_bad = (mem_addr_o[1:0] != 2'b00) ||
               ((mem_addr_o >> 2) >= ADDR_W'(MEM_WORDS));
  end

  assign capture_data = addr_bad ? '0 : mem_instr_i;

  // Error flag travels with the data it describes.
  always_comb begin
    rsp0_err_d = rsp0_err_q;
    rsp1_err_d = rsp1_err_q;
    if (gnt0) begin
      rsp0_err_d = addr_bad;
    end
    if (gnt1) begin
      rsp1_err_d = addr_bad;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp0_err_q <= 1'b0;
      rsp1_err_q <= 1'b0;
    end else begin
      rsp0_err_q <= rsp0_err_d;
      rsp1_err_q <= rsp1_err_d;
    end
  end

  assign rsp0_err_o = rsp0_err_q;
  assign rsp1_err_o = rsp1_err_q;
`else
  assign capture_data = mem_instr_i;
  assign rsp0_err_o   = 1'b0;
  assign rsp1_err_o   = 1'b0;
`endif

  // Response slots: load on grant, empty on consume, otherwise hold.
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    if (gnt0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = capture_data;
    end else if (rsp0_ready_i) begin
      rsp0_valid_d = 1'b0;
    end
    if (gnt1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = capture_data;
    end else if (rsp1_ready_i) begin
      rsp1_valid_d = 1'b0;
    end
  end

  // Starvation counter: counts consecutive losses of an eligible port 1.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt1 || !req1_valid_i) begin
      starve_cnt_d = '0;
    end else if (elig1 && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any held responses immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp0_data_o  = rsp0_data_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp1_data_o  = rsp1_data_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Brief    : Self-checking bench for imem_arbiter: directed scenarios plus a
//            randomized run against a behavioural slot/priority model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int MEM_WORDS    = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              req0_valid_i, req1_valid_i;
  logic [ADDR_W-1:0] req0_addr_i, req1_addr_i;
  logic              req0_ready_o, req1_ready_o;
  logic              rsp0_valid_o, rsp1_valid_o;
  logic [DATA_W-1:0] rsp0_data_o, rsp1_data_o;
  logic              rsp0_err_o, rsp1_err_o;
  logic              rsp0_ready_i, rsp1_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_instr_i;

  int checks   = 0;
  int failures = 0;

  imem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_ready_o(req1_ready_o),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_data_o(rsp0_data_o), .rsp0_err_o(rsp0_err_o),
    .rsp0_ready_i(rsp0_ready_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_data_o(rsp1_data_o), .rsp1_err_o(rsp1_err_o),
    .rsp1_ready_i(rsp1_ready_i),
    .mem_addr_o(mem_addr_o), .mem_instr_i(mem_instr_i)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory stand-in: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC001D00D;
  endfunction

  assign mem_instr_i = mem_word(mem_addr_o);

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef IMEM_ARB_ALIGN_CHK_EN
    return ((a % 4) != 0) || ((a / 4) >= MEM_WORDS);
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model: one slot per port plus how long port 1 has waited.
  logic        mv [2];
  logic [31:0] md [2];
  logic        me [2];
  int          p1_wait;
  logic        mg0, mg1;
  logic [31:0] maddr;

  task automatic m_reset();
    for (int p = 0; p < 2; p++) begin
      mv[p] = 1'b0; md[p] = '0; me[p] = 1'b0;
    end
    p1_wait = 0;
  endtask

  task automatic m_compute();
    logic e0, e1;
    e0 = rst_i && req0_valid_i && (!mv[0] || rsp0_ready_i);
    e1 = rst_i && req1_valid_i && (!mv[1] || rsp1_ready_i);
    mg1 = e1 && (!e0 || p1_wait >= STARVE_LIMIT);
    mg0 = e0 && !mg1;
    maddr = mg0 ? req0_addr_i : (mg1 ? req1_addr_i : 32'd0);
  endtask

  task automatic m_edge();
    logic e1;
    e1 = req1_valid_i && (!mv[1] || rsp1_ready_i);
    if (mg1 || !req1_valid_i) p1_wait = 0;
    else if (e1 && p1_wait < STARVE_LIMIT) p1_wait = p1_wait + 1;
    if (mg0) begin
      mv[0] = 1'b1; me[0] = addr_bad(maddr); md[0] = me[0] ? 32'd0 : mem_word(maddr);
    end else if (rsp0_ready_i) mv[0] = 1'b0;
    if (mg1) begin
      mv[1] = 1'b1; me[1] = addr_bad(maddr); md[1] = me[1] ? 32'd0 : mem_word(maddr);
    end else if (rsp1_ready_i) mv[1] = 1'b0;
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic r0,
                       input logic v1, input logic [31:0] a1, input logic r1);
    req0_valid_i = v0; req0_addr_i = a0; rsp0_ready_i = r0;
    req1_valid_i = v1; req1_addr_i = a1; rsp1_ready_i = r1;
  endtask

  // Advance one clock, keeping the model in step; ends 1 ns after the edge.
  task automatic tick();
    m_compute();
    @(posedge clk_i);
    m_edge();
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive(1'b1, 32'd4, 1'b1, 1'b1, 32'd8, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (req0_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%0b exp=0", req0_ready_o); end
    checks++; if (req1_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready1 got=%0b exp=0", req1_ready_o); end
    checks++; if (rsp0_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp0_valid got=%0b exp=0", rsp0_valid_o); end
    checks++; if (rsp1_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp1_valid got=%0b exp=0", rsp1_valid_o); end
    checks++; if ({rsp0_err_o, rsp1_err_o} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {rsp0_err_o, rsp1_err_o}); end
    checks++; if (rsp0_data_o !== 32'd0) begin failures++; $display("FAIL reset_rsp0_data got=%h exp=0", rsp0_data_o); end
    checks++; if (mem_addr_o !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr_o); end
    rst_i = 1'b1;
    m_reset();
    #1;
    checks++; if (req0_ready_o !== 1'b1) begin failures++; $display("FAIL release_ready0 got=%0b exp=1", req0_ready_o); end
    checks++; if (req1_ready_o !== 1'b0) begin failures++; $display("FAIL release_ready1 got=%0b exp=0", req1_ready_o); end
    checks++; if (mem_addr_o !== 32'd4) begin failures++; $display("FAIL release_mem_addr got=%h exp=4", mem_addr_o); end
    tick();
    checks++; if (rsp0_valid_o !== 1'b1 || rsp0_data_o !== mem_word(32'd4)) begin
      failures++; $display("FAIL release_rsp0 got v=%0b d=%h exp v=1 d=%h", rsp0_valid_o, rsp0_data_o, mem_word(32'd4));
    end
  endtask

  task automatic test_stream_p0();
    drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'd0, 1'b1);
      #1;
      checks++; if (req0_ready_o !== 1'b1 || mem_addr_o !== 32'(i * 4)) begin
        failures++; $display("FAIL stream_grant[%0d] got rdy=%0b addr=%h exp rdy=1 addr=%h", i, req0_ready_o, mem_addr_o, i * 4);
      end
      tick();
      checks++; if (rsp0_valid_o !== 1'b1 || rsp0_data_o !== mem_word(32'(i * 4))) begin
        failures++; $display("FAIL stream_rsp[%0d] got v=%0b d=%h exp v=1 d=%h", i, rsp0_valid_o, rsp0_data_o, mem_word(32'(i * 4)));
      end
    end
    drain();
    checks++; if (rsp0_valid_o !== 1'b0) begin failures++; $display("FAIL stream_empty got=%0b exp=0", rsp0_valid_o); end
  endtask

  task automatic test_backpressure();
    drain();
    drive(1'b1, 32'd4, 1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd8, 1'b0, 1'b1, 32'(12 + 4 * i), 1'b1);
      #1;
      checks++; if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b1 || mem_addr_o !== 32'(12 + 4 * i)) begin
        failures++; $display("FAIL bp_grant[%0d] got r0=%0b r1=%0b addr=%h exp r0=0 r1=1 addr=%h", i, req0_ready_o, req1_ready_o, mem_addr_o, 12 + 4 * i);
      end
      tick();
      checks++; if (rsp0_valid_o !== 1'b1 || rsp0_data_o !== mem_word(32'd4)) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%0b d=%h exp v=1 d=%h", i, rsp0_valid_o, rsp0_data_o, mem_word(32'd4));
      end
      checks++; if (rsp1_valid_o !== 1'b1 || rsp1_data_o !== mem_word(32'(12 + 4 * i))) begin
        failures++; $display("FAIL bp_rsp1[%0d] got v=%0b d=%h exp v=1 d=%h", i, rsp1_valid_o, rsp1_data_o, mem_word(32'(12 + 4 * i)));
      end
    end
    drive(1'b1, 32'd8, 1'b1, 1'b0, 32'd0, 1'b1);
    #1;
    checks++; if (req0_ready_o !== 1'b1) begin failures++; $display("FAIL bp_resume got=%0b exp=1", req0_ready_o); end
    tick();
    checks++; if (rsp0_data_o !== mem_word(32'd8)) begin failures++; $display("FAIL bp_reload got=%h exp=%h", rsp0_data_o, mem_word(32'd8)); end
  endtask

  task automatic test_starvation();
    drain();
    for (int i = 0; i < 15; i++) begin
      logic p1;
      p1 = ((i % 5) == 4);
      drive(1'b1, 32'(4 * (i % 16)), 1'b1, 1'b1, 32'(64 + 4 * (i % 16)), 1'b1);
      #1;
      checks++; if (req0_ready_o !== !p1 || req1_ready_o !== p1) begin
        failures++; $display("FAIL starve_pattern[%0d] got r0=%0b r1=%0b exp r0=%0b r1=%0b", i, req0_ready_o, req1_ready_o, !p1, p1);
      end
      checks++; if (mem_addr_o !== (p1 ? req1_addr_i : req0_addr_i)) begin
        failures++; $display("FAIL starve_addr[%0d] got=%h exp=%h", i, mem_addr_o, p1 ? req1_addr_i : req0_addr_i);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drain();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'd16, 1'b0);
    tick();
    checks++; if (rsp1_valid_o !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0b exp=1", rsp1_valid_o); end
    drive(1'b1, 32'd0, 1'b0, 1'b1, 32'd20, 1'b0);
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (rsp1_valid_o !== 1'b0 || rsp1_data_o !== 32'd0) begin
      failures++; $display("FAIL areset_drop got v=%0b d=%h exp v=0 d=0", rsp1_valid_o, rsp1_data_o);
    end
    checks++; if (req0_ready_o !== 1'b0 || mem_addr_o !== 32'd0) begin
      failures++; $display("FAIL areset_comb got r0=%0b addr=%h exp r0=0 addr=0", req0_ready_o, mem_addr_o);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    m_reset();
  endtask

  task automatic test_align();
    logic [31:0] exp_d;
    logic        exp_e;
    drain();
    drive(1'b1, 32'd6, 1'b1, 1'b0, 32'd0, 1'b1);
    #1;
    checks++; if (mem_addr_o !== 32'd6) begin failures++; $display("FAIL align_addr got=%h exp=6", mem_addr_o); end
    tick();
`ifdef IMEM_ARB_ALIGN_CHK_EN
    exp_e = 1'b1; exp_d = 32'd0;
`else
    exp_e = 1'b0; exp_d = mem_word(32'd6);
`endif
    checks++; if (rsp0_valid_o !== 1'b1 || rsp0_err_o !== exp_e || rsp0_data_o !== exp_d) begin
      failures++; $display("FAIL align_mis got v=%0b e=%0b d=%h exp v=1 e=%0b d=%h", rsp0_valid_o, rsp0_err_o, rsp0_data_o, exp_e, exp_d);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'd124, 1'b1);
    tick();
    checks++; if (rsp1_err_o !== 1'b0 || rsp1_data_o !== mem_word(32'd124)) begin
      failures++; $display("FAIL align_last got e=%0b d=%h exp e=0 d=%h", rsp1_err_o, rsp1_data_o, mem_word(32'd124));
    end
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'd128, 1'b1);
    tick();
`ifdef IMEM_ARB_ALIGN_CHK_EN
    exp_e = 1'b1; exp_d = 32'd0;
`else
    exp_e = 1'b0; exp_d = mem_word(32'd128);
`endif
    checks++; if (rsp1_valid_o !== 1'b1 || rsp1_err_o !== exp_e || rsp1_data_o !== exp_d) begin
      failures++; $display("FAIL align_range got v=%0b e=%0b d=%h exp v=1 e=%0b d=%h", rsp1_valid_o, rsp1_err_o, rsp1_data_o, exp_e, exp_d);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    if (($urandom % 8) == 0) return 32'($urandom % 256);
    return 32'(($urandom % 32) * 4);
  endfunction

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, pick_addr(), ($urandom % 3) != 0,
            ($urandom % 4) != 0, pick_addr(), ($urandom % 3) != 0);
      #1;
      m_compute();
      checks++; if (req0_ready_o !== mg0 || req1_ready_o !== mg1 || mem_addr_o !== maddr) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rand_grant[%0d] got r0=%0b r1=%0b addr=%h exp r0=%0b r1=%0b addr=%h",
                               i, req0_ready_o, req1_ready_o, mem_addr_o, mg0, mg1, maddr);
      end
      tick();
      checks++; if (rsp0_valid_o !== mv[0] || rsp0_data_o !== md[0] || rsp0_err_o !== me[0]) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rand_rsp0[%0d] got v=%0b d=%h e=%0b exp v=%0b d=%h e=%0b",
                               i, rsp0_valid_o, rsp0_data_o, rsp0_err_o, mv[0], md[0], me[0]);
      end
      checks++; if (rsp1_valid_o !== mv[1] || rsp1_data_o !== md[1] || rsp1_err_o !== me[1]) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rand_rsp1[%0d] got v=%0b d=%h e=%0b exp v=%0b d=%h e=%0b",
                               i, rsp1_valid_o, rsp1_data_o, rsp1_err_o, mv[1], md[1], me[1]);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_stream_p0();
    test_backpressure();
    test_starvation();
    test_async_reset();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
